// File: rtl/qwiregarb_pkg.sv
// Shared types and constants for the register-port round-robin arbiter.
package qwiregarb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERR,
        ACK
    } state_t;

    // Read data returned to a requester whose address is outside the register map.
    localparam logic [31:0] BADDATA_DEF = 32'hDEAD_BEEF;

    // Width of an index into n items; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/qwiregarb_if.sv
// Requester and register-file port bundle of the arbiter.
// slave is the arbiter view; master is the surrounding requesters plus register file.
interface qwiregarb_if #(
    parameter int NREQ = 2,
    parameter int AWID = 9,
    parameter int DWID = 32
);
    logic [NREQ-1:0]      req_vld;
    logic [NREQ*4-1:0]    req_we;
    logic [NREQ*AWID-1:0] req_addr;
    logic [NREQ*DWID-1:0] req_wrd;
    logic [NREQ-1:0]      req_ack;
    logic                 req_err;
    logic [DWID-1:0]      req_rdd;

    logic                 reg_ce;
    logic [3:0]           reg_we;
    logic [AWID-1:0]      reg_addr;
    logic [DWID-1:0]      reg_wrd;
    logic [DWID-1:0]      reg_rdd;

    modport slave (
        input  req_vld, req_we, req_addr, req_wrd, reg_rdd,
        output req_ack, req_err, req_rdd, reg_ce, reg_we, reg_addr, reg_wrd
    );

    modport master (
        output req_vld, req_we, req_addr, req_wrd, reg_rdd,
        input  req_ack, req_err, req_rdd, reg_ce, reg_we, reg_addr, reg_wrd
    );
endinterface

// File: rtl/qwiregarb_rrpick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module qwirrpick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   index
);
    logic [NREQ-1:0] rot;
    logic [PW:0]     sum;

    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        any   = 1'b0;
        index = '0;
        sum   = '0;
        rot   = NREQ'({req, req} >> ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (PW+1)'(k);
                if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
                index = sum[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/qwiregarb.sv
// Round-robin arbiter sharing the single register-file port among NREQ requesters.
// One transaction at a time; out-of-range addresses are answered locally.
//
// state | meaning
// IDLE  | waiting for any request; picks one and latches its fields
// ISSUE | single reg_ce cycle towards the register file
// WAIT  | read latency countdown; captures reg_rdd on the last cycle
// ERR   | illegal address; loads BADDATA and the error flag
// ACK   | one-cycle req_ack to the granted requester, pointer advances
module qwiregarb
    import qwiregarb_pkg::*;
#(
    parameter int              NREQ    = 2,
    parameter int              AWID    = 9,
    parameter int              DWID    = 32,
    parameter int              REGCNT  = 2,
    parameter int              RD_LAT  = 1,
    parameter logic [DWID-1:0] BADDATA = DWID'(BADDATA_DEF)
) (
    input  logic        reg_clk,
    input  logic        sys_rst_n,
    qwiregarb_if.slave  bus,
    output logic        arb_busy,
    output logic [2:0]  arb_gnt_id
);
    localparam int PW = clog2(NREQ);

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic [PW-1:0]   rr_ptr, rr_nxt;
    logic [PW-1:0]   gnt;
    logic [2:0]      gnt_nxt;
    logic [NREQ-1:0] gnt_onehot;

    logic            pick_any;
    logic [PW-1:0]   pick_idx;
    logic [3:0]      pick_we;
    logic [AWID-1:0] pick_addr;
    logic [DWID-1:0] pick_wrd;

    logic [NREQ-1:0] ack_nxt;
    logic            err_nxt;
    logic [DWID-1:0] rdd_nxt;
    logic            ce_nxt;
    logic [3:0]      we_nxt;
    logic [AWID-1:0] addr_nxt;
    logic [DWID-1:0] wrd_nxt;
    logic            busy_nxt;

    assign gnt = arb_gnt_id[PW-1:0];

    qwirrpick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (bus.req_vld),
        .ptr   (rr_ptr),
        .any   (pick_any),
        .index (pick_idx)
    );

    // Select the picked requester's fields and decode the current grant to one-hot.
    always_comb begin
        pick_we    = '0;
        pick_addr  = '0;
        pick_wrd   = '0;
        gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == pick_idx) begin
                pick_we   = bus.req_we[i*4 +: 4];
                pick_addr = bus.req_addr[i*AWID +: AWID];
                pick_wrd  = bus.req_wrd[i*DWID +: DWID];
            end
            if (PW'(i) == gnt) gnt_onehot[i] = 1'b1;
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rr_nxt    = rr_ptr;
        gnt_nxt   = arb_gnt_id;
        ack_nxt   = '0;
        err_nxt   = bus.req_err;
        rdd_nxt   = bus.req_rdd;
        ce_nxt    = 1'b0;
        we_nxt    = '0;
        addr_nxt  = bus.reg_addr;
        wrd_nxt   = bus.reg_wrd;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_nxt = 3'(pick_idx);
                    err_nxt = 1'b0;
                    if (pick_addr >= AWID'(REGCNT)) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = ISSUE;
                        ce_nxt    = 1'b1;
                        we_nxt    = pick_we;
                        addr_nxt  = pick_addr;
                        wrd_nxt   = pick_wrd;
                    end
                end
            end
            ISSUE: begin
                // reg_we still carries the latched enables during this cycle
                if (bus.reg_we != 4'b0000) begin
                    state_nxt = ACK;
                    ack_nxt   = gnt_onehot;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 3'(RD_LAT);
                end
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    rdd_nxt   = bus.reg_rdd;
                    state_nxt = ACK;
                    ack_nxt   = gnt_onehot;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            ERR: begin
                rdd_nxt   = BADDATA;
                err_nxt   = 1'b1;
                state_nxt = ACK;
                ack_nxt   = gnt_onehot;
            end
            ACK: begin
                rr_nxt    = (gnt == PW'(NREQ-1)) ? '0 : gnt + 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State, pointer and output registers.
    always_ff @(posedge reg_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= '0;
            arb_gnt_id   <= '0;
            arb_busy     <= 1'b0;
            bus.req_ack  <= '0;
            bus.req_err  <= 1'b0;
            bus.req_rdd  <= '0;
            bus.reg_ce   <= 1'b0;
            bus.reg_we   <= '0;
            bus.reg_addr <= '0;
            bus.reg_wrd  <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rr_ptr       <= rr_nxt;
            arb_gnt_id   <= gnt_nxt;
            arb_busy     <= busy_nxt;
            bus.req_ack  <= ack_nxt;
            bus.req_err  <= err_nxt;
            bus.req_rdd  <= rdd_nxt;
            bus.reg_ce   <= ce_nxt;
            bus.reg_we   <= we_nxt;
            bus.reg_addr <= addr_nxt;
            bus.reg_wrd  <= wrd_nxt;
        end
    end
endmodule
